// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache merge arbiter: default lane width and FSM encoding.
package cache_ctrl_pkg;

  localparam int CMERGE_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cache_merge_arb_if.sv
// Bus bundle between two requesters, the merge arbiter and the downstream sink.
// o_starve exists only when CMERGE_STARVE_MON_EN is defined.
interface cache_merge_arb_if
  import cache_ctrl_pkg::*;
#(
  parameter int DATA_W = CMERGE_DATA_W
) ();

  logic              i_req0;
  logic              i_req1;
  logic [DATA_W-1:0] i_data0;
  logic [DATA_W-1:0] i_data1;
  logic              i_last0;
  logic              i_last1;
  logic              o_gnt0;
  logic              o_gnt1;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              o_src;
  logic              i_ready;
`ifdef CMERGE_STARVE_MON_EN
  logic [1:0]        o_starve;
`endif

  // Requesters and downstream sink side.
  modport master (
    output i_req0, i_req1, i_data0, i_data1, i_last0, i_last1, i_ready,
`ifdef CMERGE_STARVE_MON_EN
    input  o_starve,
`endif
    input  o_gnt0, o_gnt1, o_valid, o_data, o_src
  );

  // Arbiter side.
  modport slave (
    input  i_req0, i_req1, i_data0, i_data1, i_last0, i_last1, i_ready,
`ifdef CMERGE_STARVE_MON_EN
    output o_starve,
`endif
    output o_gnt0, o_gnt1, o_valid, o_data, o_src
  );

endinterface

// File: rtl/cache_merge_arb_starve_cnt.sv
// Per-requester saturating wait counter with registered starvation flag.
// Only built when CMERGE_STARVE_MON_EN is defined.
`ifdef CMERGE_STARVE_MON_EN
module cmerge_starve_cnt #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic req_i,
  input  logic gnt_i,
  output logic starve_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          starve_q, starve_d;

  // Count waiting cycles, saturating at MAX_WAIT; a grant or a dropped request clears it.
  always_comb begin
    cnt_d    = cnt_q;
    starve_d = req_i & ~gnt_i & (cnt_q >= CW'(MAX_WAIT));
    if (req_i && !gnt_i) begin
      if (cnt_q < CW'(MAX_WAIT)) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  assign starve_o = starve_q;

endmodule
`endif

// File: rtl/cache_merge_arb.sv
// Two-input burst-locking round-robin merge arbiter with a one-deep registered output slot.
// Optional per-requester starvation monitor enabled by CMERGE_STARVE_MON_EN.
module cache_merge_arb
  import cache_ctrl_pkg::*;
#(
  parameter int DATA_W   = CMERGE_DATA_W,
  parameter int MAX_WAIT = 8
) (
  input logic              clk,
  input logic              rstn,
  cache_merge_arb_if.slave bus
);

  arb_state_e        state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic              o_valid_q, o_valid_d;
  logic              o_src_q, o_src_d;
  logic [DATA_W-1:0] o_data_q, o_data_d;

  logic sel_s;
  logic slot_free_s;
  logic gnt0_s, gnt1_s, gnt_s;
  logic last_s;

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("cache_merge_arb: MAX_WAIT must be at least 1");
  end

  // Pick a requester: the burst owner while locked, otherwise prio unless it is idle.
  always_comb begin
    sel_s = 1'b0;
    if (state_q == LOCK) begin
      sel_s = owner_q;
    end else if (prio_q ? bus.i_req1 : bus.i_req0) begin
      sel_s = prio_q;
    end else begin
      sel_s = ~prio_q;
    end
  end

  assign slot_free_s = ~o_valid_q | bus.i_ready;
  assign gnt0_s      = ~sel_s & bus.i_req0 & slot_free_s;
  assign gnt1_s      =  sel_s & bus.i_req1 & slot_free_s;
  assign gnt_s       = gnt0_s | gnt1_s;
  assign last_s      = sel_s ? bus.i_last1 : bus.i_last0;

  // Output slot: load on grant, drain on ready, otherwise hold.
  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_src_d   = o_src_q;
    if (gnt_s) begin
      o_valid_d = 1'b1;
      o_data_d  = sel_s ? bus.i_data1 : bus.i_data0;
      o_src_d   = sel_s;
    end else if (bus.i_ready) begin
      o_valid_d = 1'b0;
    end else begin
      o_valid_d = o_valid_q;
    end
  end

  // Burst lock FSM and round-robin pointer update.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (gnt_s) begin
          if (last_s) begin
            prio_d = ~sel_s;
          end else begin
            state_d = LOCK;
            owner_d = sel_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOCK: begin
        if (gnt_s && last_s) begin
          state_d = IDLE;
          prio_d  = ~owner_q;
        end else begin
          state_d = LOCK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      o_valid_q <= 1'b0;
      o_src_q   <= 1'b0;
      o_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      o_valid_q <= o_valid_d;
      o_src_q   <= o_src_d;
      o_data_q  <= o_data_d;
    end
  end

  assign bus.o_gnt0  = gnt0_s;
  assign bus.o_gnt1  = gnt1_s;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_src   = o_src_q;

`ifdef CMERGE_STARVE_MON_EN
  logic starve0_s, starve1_s;

  cmerge_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve0 (
    .clk      (clk),
    .rstn     (rstn),
    .req_i    (bus.i_req0),
    .gnt_i    (gnt0_s),
    .starve_o (starve0_s)
  );

  cmerge_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve1 (
    .clk      (clk),
    .rstn     (rstn),
    .req_i    (bus.i_req1),
    .gnt_i    (gnt1_s),
    .starve_o (starve1_s)
  );

  assign bus.o_starve = {starve1_s, starve0_s};
`endif

endmodule

// File: tb/tb_cache_merge_arb.sv
// Directed scoreboard bench for cache_merge_arb; the starvation section runs when
// CMERGE_STARVE_MON_EN is defined.
module tb_cache_merge_arb;
  import cache_ctrl_pkg::*;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  int   beat_n;
  logic [32:0] sb_q[$];
  logic [1:0]  exp_starve;

  cache_merge_arb_if #(.DATA_W(32)) bus ();

  cache_merge_arb #(.DATA_W(32), .MAX_WAIT(8)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic l0, input logic r1, input logic l1,
                       input logic rdy);
    logic [15:0] tag_v;
    beat_n++;
    tag_v       = beat_n[15:0];
    bus.i_req0  = r0;
    bus.i_last0 = l0;
    bus.i_req1  = r1;
    bus.i_last1 = l1;
    bus.i_ready = rdy;
    bus.i_data0 = {16'hD000, tag_v};
    bus.i_data1 = {16'hE000, tag_v};
  endtask

  // One clock: check grants, the output slot against the scoreboard, then record new grants.
  task automatic cycle(input logic eg0, input logic eg1);
    @(negedge clk);
    chk("o_gnt0", bus.o_gnt0, eg0);
    chk("o_gnt1", bus.o_gnt1, eg1);
    chk("o_valid", bus.o_valid, logic'(sb_q.size() != 0));
    if (sb_q.size() != 0) begin
      chk("o_src_data", {bus.o_src, bus.o_data}, sb_q[0]);
      if (bus.i_ready) void'(sb_q.pop_front());
    end
`ifdef CMERGE_STARVE_MON_EN
    chk("o_starve", bus.o_starve, exp_starve);
`endif
    if (eg0) sb_q.push_back({1'b0, bus.i_data0});
    if (eg1) sb_q.push_back({1'b1, bus.i_data1});
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk        = 1'b0;
    rstn       = 1'b0;
    checks     = 0;
    errors     = 0;
    beat_n     = 0;
    exp_starve = 2'b00;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset values.
    #12;
    chk("rst_o_valid", bus.o_valid, 1'b0);
    chk("rst_o_data", bus.o_data, 32'h0);
    chk("rst_o_src", bus.o_src, 1'b0);
    chk("rst_gnt", {bus.o_gnt1, bus.o_gnt0}, 2'b00);
`ifdef CMERGE_STARVE_MON_EN
    chk("rst_o_starve", bus.o_starve, 2'b00);
`endif
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single-beat traffic from both: grants alternate 0,1,0,1.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1); cycle(1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1); cycle(1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1); cycle(1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1); cycle(1'b0, 1'b1);

    // Three-beat burst on requester 1 while requester 0 stays asserted.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1); cycle(1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1); cycle(1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1); cycle(1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1); cycle(1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1); cycle(1'b1, 1'b0);

    // Owner drops its request mid-burst: lock holds and the other side waits.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1); cycle(1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1); cycle(1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1); cycle(1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1); cycle(1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1); cycle(1'b1, 1'b0);

    // Backpressure: hold 0xA5A5A5A5 for four stalled cycles, then resume.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.i_data0 = 32'hA5A5A5A5;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); cycle(1'b0, 1'b0);
    end
    chk("stall_o_data", bus.o_data, 32'hA5A5A5A5);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1); cycle(1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cycle(1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cycle(1'b0, 1'b0);

    // Reset pulse in the middle of a requester-1 burst.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1); cycle(1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1); cycle(1'b0, 1'b1);
    #1;
    rstn = 1'b0;
    #1;
    chk("midrst_o_valid", bus.o_valid, 1'b0);
    chk("midrst_o_data", bus.o_data, 32'h0);
    chk("midrst_o_src", bus.o_src, 1'b0);
    sb_q.delete();
    #1;
    rstn = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1); cycle(1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cycle(1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cycle(1'b0, 1'b0);

`ifdef CMERGE_STARVE_MON_EN
    // Twelve-beat burst on requester 0 starves requester 1.
    #1;
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    sb_q.delete();
    for (int k = 0; k < 12; k++) begin
      exp_starve = {logic'(k >= 9), 1'b0};
      drive(1'b1, logic'(k == 11), 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b0);
    end
    exp_starve = 2'b10;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1); cycle(1'b0, 1'b1);
    exp_starve = 2'b00;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cycle(1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cycle(1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_merge_arb.md
CACHE_MERGE_ARB -- requirements
Module: cache_merge_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of each data lane.
REQ-002 SHALL have parameter MAX_WAIT, default 8, meaning starvation threshold in cycles (used only with CMERGE_STARVE_MON_EN).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports i_req0 and i_req1, each input 1, meaning requester beat valid.
REQ-006 SHALL have ports i_data0 and i_data1, each input DATA_W, meaning requester beat payload.
REQ-007 SHALL have ports i_last0 and i_last1, each input 1, meaning final beat of a burst.
REQ-008 SHALL have ports o_gnt0 and o_gnt1, each output 1, meaning beat accepted this cycle.
REQ-009 SHALL have port o_valid  output  1  merged beat valid.
REQ-010 SHALL have port o_data  output  DATA_W  merged beat payload.
REQ-011 SHALL have port o_src  output  1  source index of the beat on o_data.
REQ-012 SHALL have port i_ready  input  1  downstream accepts o_data this cycle.
REQ-013 SHALL have port o_starve  output  2  per-requester starvation flag, present only with CMERGE_STARVE_MON_EN.

Function
REQ-014 SHALL implement states IDLE and LOCK, plus a 1-bit round-robin pointer prio and a 1-bit owner.
REQ-015 SHALL select the owner in LOCK; in IDLE SHALL select prio if its i_req is 1, else the other requester.
REQ-016 SHALL define slot_free = ~o_valid | i_ready.
REQ-017 SHALL assert o_gnt<k> combinationally iff k is selected, i_req<k>=1 and slot_free=1.
REQ-018 SHALL never assert o_gnt0 and o_gnt1 in the same cycle.
REQ-019 SHALL load o_data, o_src and o_valid=1 on the edge after a grant; latency is one cycle.
REQ-020 SHALL hold o_valid, o_data and o_src stable while o_valid=1 and i_ready=0.
REQ-021 SHALL clear o_valid when i_ready=1 and no grant occurs in that cycle.
REQ-022 SHALL move IDLE->LOCK with owner=k on a granted beat with i_last<k>=0.
REQ-023 SHALL keep the IDLE state on a granted beat with i_last<k>=1 and set prio to ~k.
REQ-024 SHALL move LOCK->IDLE on a granted owner beat with i_last=1 and set prio to ~owner.
REQ-025 SHALL ignore the non-owner in LOCK, whose i_req is held pending without any grant.
REQ-026 SHALL stay in LOCK while the owner drops i_req mid-burst; no timeout applies.
REQ-027 SHALL grant prio when both requesters are asserted in the same IDLE cycle.
REQ-028 SHALL allow back-to-back grants every cycle while i_ready=1, giving full throughput.

Reset
REQ-029 SHALL on rstn=0 asynchronously set state=IDLE, prio=0, owner=0, o_valid=0, o_data=0, o_src=0, and all starvation counters and o_starve=0.
REQ-030 SHALL abandon any burst in flight when reset is applied mid-operation; the first beat after release is arbitrated from IDLE.

Configuration
REQ-031 SHALL with macro CMERGE_STARVE_MON_EN defined keep one saturating counter per requester, sized $clog2(MAX_WAIT+1) bits.
REQ-032 SHALL increment that counter each cycle i_req<k>=1 and o_gnt<k>=0, and clear it on a grant or when i_req<k>=0.
REQ-033 SHALL register o_starve<k>=1 while counter k >= MAX_WAIT.
REQ-034 SHALL without CMERGE_STARVE_MON_EN omit the counters and the o_starve port entirely.

Structure
REQ-035 SHALL place the state encoding (IDLE=0, LOCK=1) and the default DATA_W in the shared package cache_ctrl_pkg.
REQ-036 SHALL implement the starvation counter as sub-module cmerge_starve_cnt, instantiated once per requester.

Verification
REQ-037 SHALL cover: after reset, i_req0=i_req1=1, i_last=1, i_ready=1 -> grants alternate 0,1,0,1 and o_src follows one cycle later.
REQ-038 SHALL cover: a 3-beat burst on requester 1 (i_last1=0,0,1) with i_req0 held high -> o_gnt1 for 3 consecutive cycles, then o_gnt0.
REQ-039 SHALL cover: i_ready=0 for 4 cycles with o_valid=1 and o_data=0xA5A5A5A5 -> o_data stable and no grant; grant resumes in the cycle i_ready returns to 1.
REQ-040 SHALL cover: rstn pulsed low mid-burst -> o_valid=0 and state IDLE immediately; next grant goes to requester 0.
REQ-041 SHALL cover, with CMERGE_STARVE_MON_EN and MAX_WAIT=8, a 12-beat burst on requester 0 while i_req1=1 -> o_starve[1] rises 9 cycles after i_req1 rises and clears the cycle after o_gnt1.
